// File: rtl/calc_serial_rx.sv
// Serial word receiver for the calculator transmitter: collects BEATS beats of OUTSIZE bits
// MSB-first into a 32-bit word. Optional input synchroniser enabled by macro CALC_RX_SYNC_EN.
module calc_serial_rx #(
    parameter int unsigned OUTSIZE = 1
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               ClkTx,
    input  logic               DOutValid,
    input  logic [OUTSIZE-1:0] DataOut,
    output logic [31:0]        RxData,
    output logic               RxValid,
    output logic               Busy,
    output logic               FrameErr
);

    localparam int unsigned BEATS = 32 / OUTSIZE;
    localparam int unsigned CW = $clog2(BEATS) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    logic [OUTSIZE+1:0] in_bus;

`ifdef CALC_RX_SYNC_EN
    localparam int unsigned STAGES = 3;
    logic [OUTSIZE+1:0] sync1, sync2;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {ClkTx, DOutValid, DataOut};
            sync2 <= sync1;
        end
    end

    assign in_bus = sync2;
`else
    localparam int unsigned STAGES = 1;
    assign in_bus = {ClkTx, DOutValid, DataOut};
`endif

    logic               clktx_s, valid_s, clktx_q;
    logic [OUTSIZE-1:0] data_s;
    logic [STAGES-1:0]  fill;
    logic               armed;
    logic               beat;

    // fill marks when the sample stage holds real input rather than reset zeros; a beat is only
    // honoured once a genuine low phase of ClkTx has been seen.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            clktx_s <= 1'b0;
            valid_s <= 1'b0;
            data_s  <= '0;
            clktx_q <= 1'b0;
            fill    <= '0;
            armed   <= 1'b0;
        end else begin
            {clktx_s, valid_s, data_s} <= in_bus;
            clktx_q <= clktx_s;
            fill    <= STAGES'({fill, 1'b1});
            armed   <= armed | (fill[STAGES-1] & ~clktx_s);
        end
    end

    assign beat = clktx_s & ~clktx_q & armed;

    state_e          state;
    logic [CW-1:0]   beat_cnt;
    logic [31:0]     shreg;
    logic [31:0]     word_next;
    logic [4:0]      pos;

    assign pos = 5'(31 - int'(beat_cnt) * int'(OUTSIZE));

    always_comb begin
        word_next = (state == StIdle) ? 32'h0 : shreg;
        word_next[pos -: OUTSIZE] = data_s;
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state    <= StIdle;
            beat_cnt <= '0;
            shreg    <= '0;
            RxData   <= '0;
            RxValid  <= 1'b0;
            Busy     <= 1'b0;
            FrameErr <= 1'b0;
        end else begin
            RxValid  <= 1'b0;
            FrameErr <= 1'b0;
            case (state)
                StIdle: begin
                    if (beat && valid_s) begin
                        shreg <= word_next;
                        if (BEATS == 1) begin
                            state   <= StDone;
                            RxData  <= word_next;
                            RxValid <= 1'b1;
                        end else begin
                            state    <= StShift;
                            beat_cnt <= CW'(1);
                            Busy     <= 1'b1;
                        end
                    end
                end
                StShift: begin
                    if (!valid_s) begin
                        state    <= StIdle;
                        beat_cnt <= '0;
                        shreg    <= '0;
                        Busy     <= 1'b0;
                        FrameErr <= 1'b1;
                    end else if (beat) begin
                        shreg <= word_next;
                        if (beat_cnt == LAST_BEAT) begin
                            state    <= StDone;
                            beat_cnt <= '0;
                            RxData   <= word_next;
                            RxValid  <= 1'b1;
                            Busy     <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                    end
                end
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_serial_rx.sv
// Randomised bench for calc_serial_rx: four instances (OUTSIZE 1, 4, 8, 32) checked against a
// word-level model (expected words, pulse counts, latency, busy span).
module tb_calc_serial_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        Reset;
    logic        ctx [4];
    logic        dv  [4];
    logic [0:0]  d0;
    logic [3:0]  d1;
    logic [7:0]  d2;
    logic [31:0] d3;
    logic [31:0] rxd  [4];
    logic        rxv  [4];
    logic        busy [4];
    logic        ferr [4];

    calc_serial_rx #(.OUTSIZE(1)) u_os1 (
        .clk(clk), .Reset(Reset), .ClkTx(ctx[0]), .DOutValid(dv[0]), .DataOut(d0),
        .RxData(rxd[0]), .RxValid(rxv[0]), .Busy(busy[0]), .FrameErr(ferr[0]));
    calc_serial_rx #(.OUTSIZE(4)) u_os4 (
        .clk(clk), .Reset(Reset), .ClkTx(ctx[1]), .DOutValid(dv[1]), .DataOut(d1),
        .RxData(rxd[1]), .RxValid(rxv[1]), .Busy(busy[1]), .FrameErr(ferr[1]));
    calc_serial_rx #(.OUTSIZE(8)) u_os8 (
        .clk(clk), .Reset(Reset), .ClkTx(ctx[2]), .DOutValid(dv[2]), .DataOut(d2),
        .RxData(rxd[2]), .RxValid(rxv[2]), .Busy(busy[2]), .FrameErr(ferr[2]));
    calc_serial_rx #(.OUTSIZE(32)) u_os32 (
        .clk(clk), .Reset(Reset), .ClkTx(ctx[3]), .DOutValid(dv[3]), .DataOut(d3),
        .RxData(rxd[3]), .RxValid(rxv[3]), .Busy(busy[3]), .FrameErr(ferr[3]));

`ifdef CALC_RX_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    int n_chk = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int os_of(input int idx);
        case (idx)
            0:       return 1;
            1:       return 4;
            2:       return 8;
            default: return 32;
        endcase
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: queue of words that must arrive, plus per-instance pulse counts and held RxData.
    typedef struct {
        int          idx;
        logic [31:0] word;
        int          rise;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int          rxv_cnt  [4] = '{0, 0, 0, 0};
    int          ferr_cnt [4] = '{0, 0, 0, 0};
    int          busy_cnt [4] = '{0, 0, 0, 0};
    int          exp_rxv  [4] = '{0, 0, 0, 0};
    int          exp_ferr [4] = '{0, 0, 0, 0};
    logic [31:0] exp_data [4] = '{32'h0, 32'h0, 32'h0, 32'h0};

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (busy[i]) busy_cnt[i]++;
            if (ferr[i]) ferr_cnt[i]++;
            if (rxv[i]) begin
                rxv_cnt[i]++;
                if (exp_q.size() == 0) begin
                    check_eq("rxvalid_expected", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("rxvalid_instance", i, mon_e.idx);
                    check_eq("rxdata", rxd[i], mon_e.word);
                    check_eq("latency", cyc - mon_e.rise, LAT);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input int idx, input logic [31:0] b);
        case (idx)
            0:       d0 = b[0:0];
            1:       d1 = b[3:0];
            2:       d2 = b[7:0];
            default: d3 = b;
        endcase
        ctx[idx] = 1'b1;
        dv[idx]  = 1'b1;
    endtask

    task automatic send_beats(input int idx, input logic [31:0] w, input int nbeats,
                              input int ph_hi, input int ph_lo,
                              output int first, output int last);
        int os;
        os = os_of(idx);
        first = 0;
        last = 0;
        for (int k = 0; k < nbeats; k++) begin
            drive_beat(idx, w >> (32 - (k + 1) * os));
            if (k == 0) first = cyc;
            last = cyc;
            if (k == nbeats - 1 && nbeats == 32 / os) begin
                exp_q.push_back('{idx: idx, word: w, rise: cyc});
                exp_data[idx] = w;
                exp_rxv[idx]++;
            end
            tick(ph_hi);
            ctx[idx] = 1'b0;
            tick(ph_lo);
        end
    endtask

    task automatic good_word(input int idx, input logic [31:0] w, input int ph_hi,
                             input int ph_lo);
        int b0, first, last;
        b0 = busy_cnt[idx];
        send_beats(idx, w, 32 / os_of(idx), ph_hi, ph_lo, first, last);
        tick(8);
        check_eq("busy_span", busy_cnt[idx] - b0, last - first);
        check_eq("rxvalid_count", rxv_cnt[idx], exp_rxv[idx]);
        check_eq("frameerr_count", ferr_cnt[idx], exp_ferr[idx]);
        check_eq("rxdata_held", rxd[idx], exp_data[idx]);
    endtask

    task automatic bad_word(input int idx, input logic [31:0] w, input int nb, input int ph_hi,
                            input int ph_lo);
        int first, last;
        send_beats(idx, w, nb, ph_hi, ph_lo, first, last);
        dv[idx] = 1'b0;
        exp_ferr[idx]++;
        tick(8);
        check_eq("abort_frameerr", ferr_cnt[idx], exp_ferr[idx]);
        check_eq("abort_rxvalid", rxv_cnt[idx], exp_rxv[idx]);
        check_eq("abort_rxdata", rxd[idx], exp_data[idx]);
        check_eq("abort_busy", busy[idx], 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, last, beats;
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ctx[i] = 1'b0;
            dv[i]  = 1'b0;
        end
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        tick(3);
        for (int i = 0; i < 4; i++) begin
            check_eq("reset_rxdata", rxd[i], 32'h0);
            check_eq("reset_rxvalid", rxv[i], 1'b0);
            check_eq("reset_busy", busy[i], 1'b0);
            check_eq("reset_frameerr", ferr[i], 1'b0);
        end
        Reset = 1'b1;
        tick(3);

        good_word(0, 32'hA5C3_0F81, 2, 2);
        good_word(2, 32'hDEAD_BEEF, 2, 2);
        good_word(1, 32'h0000_00FF, 2, 2);
        bad_word(1, 32'h1234_5678, 3, 2, 2);

        // Back-to-back single-beat words with minimum phases.
        send_beats(3, 32'h1, 1, 2, 2, first, last);
        send_beats(3, 32'h2, 1, 2, 2, first, last);
        tick(8);
        check_eq("b2b_rxvalid_count", rxv_cnt[3], exp_rxv[3]);
        check_eq("b2b_rxdata", rxd[3], 32'h2);

        for (int idx = 0; idx < 4; idx++) begin
            beats = 32 / os_of(idx);
            for (int r = 0; r < 4; r++) begin
                if (beats > 1 && $urandom_range(0, 2) == 0)
                    bad_word(idx, $urandom, $urandom_range(1, beats - 1),
                             $urandom_range(2, 4), $urandom_range(2, 4));
                else
                    good_word(idx, $urandom, $urandom_range(2, 4), $urandom_range(2, 4));
            end
        end

        // Reset mid-word, with ClkTx held high across the reset release.
        send_beats(0, 32'h0F0F_0F0F, 10, 2, 2, first, last);
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) exp_data[i] = 32'h0;
        ctx[0] = 1'b1;
        dv[0]  = 1'b1;
        tick(2);
        check_eq("midreset_rxdata", rxd[0], exp_data[0]);
        check_eq("midreset_busy", busy[0], 1'b0);
        Reset = 1'b1;
        tick(6);
        check_eq("post_reset_high_clktx_busy", busy[0], 1'b0);
        check_eq("post_reset_rxvalid", rxv_cnt[0], exp_rxv[0]);
        check_eq("post_reset_frameerr", ferr_cnt[0], exp_ferr[0]);
        check_eq("post_reset_rxdata_os8", rxd[2], exp_data[2]);
        ctx[0] = 1'b0;
        tick(3);
        good_word(0, 32'hFFFF_FFFF, 2, 2);

        check_eq("pending_words", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
